// File: rtl/sap1_controller_sequencer_pkg.sv
// SAP-1 controller/sequencer shared definitions: opcodes, control-word layout,
// named control words and one-hot T-state encodings.
package sap1_pkg;

    typedef enum logic [3:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    localparam int CON_W = 12;

    // Bit positions in CON; _N bits are active-low.
    localparam int CON_CP   = 11;
    localparam int CON_EP   = 10;
    localparam int CON_LM_N = 9;
    localparam int CON_CE_N = 8;
    localparam int CON_LI_N = 7;
    localparam int CON_EI_N = 6;
    localparam int CON_LA_N = 5;
    localparam int CON_EA   = 4;
    localparam int CON_SU   = 3;
    localparam int CON_EU   = 2;
    localparam int CON_LB_N = 1;
    localparam int CON_LO_N = 0;

    localparam logic [CON_W-1:0] CON_IDLE    = 12'h3E3;
    localparam logic [CON_W-1:0] CON_T1      = 12'h5E3;
    localparam logic [CON_W-1:0] CON_T2      = 12'hBE3;
    localparam logic [CON_W-1:0] CON_T3      = 12'h263;
    localparam logic [CON_W-1:0] CON_MAR_IR  = 12'h1A3;
    localparam logic [CON_W-1:0] CON_OUT     = 12'h3F2;
    localparam logic [CON_W-1:0] CON_LDA_RAM = 12'h2C3;
    localparam logic [CON_W-1:0] CON_B_RAM   = 12'h2E1;
    localparam logic [CON_W-1:0] CON_ADD     = 12'h3C7;
    localparam logic [CON_W-1:0] CON_SUB     = 12'h3CF;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

endpackage

// File: rtl/sap1_controller_sequencer_if.sv
// Opcode in, ring state / control word / halt out, between the SAP-1
// controller and the datapath it steers.
interface sap1_ctrl_if #(parameter int OPCODE_W = 4);
    logic [OPCODE_W-1:0] OPCODE;
    logic [5:0]          T;
    logic [11:0]         CON;
    logic                HLT;

    modport master (input OPCODE, output T, output CON, output HLT);
    modport slave  (output OPCODE, input T, input CON, input HLT);
endinterface

// File: rtl/sap1_controller_sequencer_ring.sv
// Six-state one-hot ring counter: clear and load-T1 beat hold, hold beats advance.
module ring_counter_6
    import sap1_pkg::*;
(
    input  logic       CLK,
    input  logic       CLR,
    input  logic       hold,
    input  logic       load_t1,
    output logic [5:0] t
);
    logic [5:0] t_q;

    always_ff @(posedge CLK) begin
        if (CLR)          t_q <= T1;
        else if (load_t1) t_q <= T1;
        else if (hold)    t_q <= t_q;
        else              t_q <= {t_q[4:0], t_q[5]};
    end

    assign t = t_q;
endmodule

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller/sequencer: ring counter, halt latch and control matrix.
// Define SAP1_SHORT_CYCLE_EN to end short instructions early (variable machine cycle).
module sap1_controller_sequencer
    import sap1_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic         CLK,
    input  logic         CLR,
    sap1_ctrl_if.master  bus
);
    if (OPCODE_W != 4) begin : g_bad_opcode_w
        $error("sap1_controller_sequencer: OPCODE_W must be 4");
    end

    logic [5:0] t;
    logic [3:0] op;
    logic       hlt_q;
    logic       halt_now;
    logic       short_ret;
    logic       load_t1;
    logic [CON_W-1:0] con;

    assign op       = bus.OPCODE[3:0];
    assign halt_now = !hlt_q && (t == T4) && (op == OP_HLT);

`ifdef SAP1_SHORT_CYCLE_EN
    // OUT/NOP finish after T4, LDA after T5; HLT freezes at T4 instead.
    assign short_ret = !hlt_q &&
        (((t == T4) && !(op inside {OP_LDA, OP_ADD, OP_SUB, OP_HLT})) ||
         ((t == T5) && (op == OP_LDA)));
`else
    assign short_ret = 1'b0;
`endif

    // A corrupted (non-one-hot) ring is recovered even while halted.
    assign load_t1 = !$onehot(t) || short_ret;

    ring_counter_6 u_ring (
        .CLK     (CLK),
        .CLR     (CLR),
        .hold    (hlt_q || halt_now),
        .load_t1 (load_t1),
        .t       (t)
    );

    always_ff @(posedge CLK) begin
        if (CLR)           hlt_q <= 1'b0;
        else if (halt_now) hlt_q <= 1'b1;
    end

    always_comb begin
        con = CON_IDLE;
        if (!hlt_q) begin
            case (t)
                T1: con = CON_T1;
                T2: con = CON_T2;
                T3: con = CON_T3;
                T4: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB: con = CON_MAR_IR;
                        OP_OUT:                 con = CON_OUT;
                        default:                con = CON_IDLE;
                    endcase
                end
                T5: begin
                    case (op)
                        OP_LDA:         con = CON_LDA_RAM;
                        OP_ADD, OP_SUB: con = CON_B_RAM;
                        default:        con = CON_IDLE;
                    endcase
                end
                T6: begin
                    case (op)
                        OP_ADD:  con = CON_ADD;
                        OP_SUB:  con = CON_SUB;
                        default: con = CON_IDLE;
                    endcase
                end
                default: con = CON_IDLE;
            endcase
        end
    end

    assign bus.T   = t;
    assign bus.HLT = hlt_q;
    assign bus.CON = con;
endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Bench for sap1_controller_sequencer: directed scenarios plus random opcode/reset traffic.
module tb_sap1_controller_sequencer;
    logic CLK;
    logic CLR;
    int   passed;
    int   total;

    sap1_ctrl_if #(.OPCODE_W(4)) bus ();

    sap1_controller_sequencer #(.OPCODE_W(4)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

`ifdef SAP1_SHORT_CYCLE_EN
    localparam int NOP_LEN = 4;
    localparam int LDA_LEN = 5;
`else
    localparam int NOP_LEN = 6;
    localparam int LDA_LEN = 6;
`endif

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: position within the instruction (1..6) plus halt flag.
    int   m_step;
    logic m_hlt;

    function automatic int instr_len(input logic [3:0] op);
        if (op == 4'd1 || op == 4'd2) return 6;
        if (op == 4'd0) return LDA_LEN;
        return NOP_LEN;
    endfunction

    function automatic logic [11:0] exp_con(input int step, input logic [3:0] op, input logic hlt);
        if (hlt) return 12'h3E3;
        case (step)
            1: return 12'h5E3;
            2: return 12'hBE3;
            3: return 12'h263;
            4: return (op <= 4'd2) ? 12'h1A3 : (op == 4'hE) ? 12'h3F2 : 12'h3E3;
            5: return (op == 4'd0) ? 12'h2C3 : (op == 4'd1 || op == 4'd2) ? 12'h2E1 : 12'h3E3;
            6: return (op == 4'd1) ? 12'h3C7 : (op == 4'd2) ? 12'h3CF : 12'h3E3;
            default: return 12'h3E3;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] seq [3];
        seq = '{12'h5E3, 12'hBE3, 12'h263};
        bus.OPCODE = 4'h3;
        CLR = 1'b1;
        tick();
        tick();
        total++;
        if ({bus.T, bus.HLT, bus.CON} !== {6'b000001, 1'b0, 12'h5E3})
            $display("FAIL reset_state: got T=%b HLT=%b CON=%h, want T=000001 HLT=0 CON=5e3", bus.T, bus.HLT, bus.CON);
        else passed++;
        CLR = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.OPCODE = 4'($urandom);
            #1;
            total++;
            if ({bus.T, bus.CON} !== {6'(1 << i), seq[i]})
                $display("FAIL reset_release_t%0d: got T=%b CON=%h, want T=%b CON=%h", i + 1, bus.T, bus.CON, 6'(1 << i), seq[i]);
            else passed++;
            tick();
        end
    endtask

    task automatic test_lda();
        logic [11:0] seq [3];
        seq = '{12'h1A3, 12'h2C3, 12'h3E3};
        do_reset();
        bus.OPCODE = 4'h0;
        repeat (3) tick();
        for (int i = 0; i < LDA_LEN - 3; i++) begin
            total++;
            if ({bus.T, bus.CON} !== {6'(8 << i), seq[i]})
                $display("FAIL lda_t%0d: got T=%b CON=%h, want T=%b CON=%h", i + 4, bus.T, bus.CON, 6'(8 << i), seq[i]);
            else passed++;
            tick();
        end
        total++;
        if ({bus.T, bus.CON} !== {6'b000001, 12'h5E3})
            $display("FAIL lda_wrap: got T=%b CON=%h, want T=000001 CON=5e3", bus.T, bus.CON);
        else passed++;
    endtask

    task automatic test_add_sub();
        logic [11:0] t6w;
        do_reset();
        for (int k = 1; k <= 2; k++) begin
            bus.OPCODE = 4'(k);
            t6w = (k == 1) ? 12'h3C7 : 12'h3CF;
            repeat (4) tick();
            total++;
            if ({bus.T, bus.CON} !== {6'b010000, 12'h2E1})
                $display("FAIL op%0d_t5: got T=%b CON=%h, want T=010000 CON=2e1", k, bus.T, bus.CON);
            else passed++;
            tick();
            total++;
            if ({bus.T, bus.CON} !== {6'b100000, t6w})
                $display("FAIL op%0d_t6: got T=%b CON=%h, want T=100000 CON=%h", k, bus.T, bus.CON, t6w);
            else passed++;
            tick();
        end
        total++;
        if (bus.T !== 6'b000001)
            $display("FAIL add_sub_wrap: got T=%b, want T=000001", bus.T);
        else passed++;
    endtask

    task automatic test_out_hlt();
        do_reset();
        bus.OPCODE = 4'hE;
        repeat (3) tick();
        total++;
        if ({bus.T, bus.CON} !== {6'b001000, 12'h3F2})
            $display("FAIL out_t4: got T=%b CON=%h, want T=001000 CON=3f2", bus.T, bus.CON);
        else passed++;
        repeat (NOP_LEN - 3) tick();
        total++;
        if (bus.T !== 6'b000001)
            $display("FAIL out_wrap: got T=%b, want T=000001", bus.T);
        else passed++;
        bus.OPCODE = 4'hF;
        repeat (3) tick();
        total++;
        if ({bus.T, bus.HLT, bus.CON} !== {6'b001000, 1'b0, 12'h3E3})
            $display("FAIL hlt_t4: got T=%b HLT=%b CON=%h, want T=001000 HLT=0 CON=3e3", bus.T, bus.HLT, bus.CON);
        else passed++;
        tick();
        for (int i = 0; i < 20; i++) begin
            total++;
            if ({bus.T, bus.HLT, bus.CON} !== {6'b001000, 1'b1, 12'h3E3})
                $display("FAIL halted_c%0d: got T=%b HLT=%b CON=%h, want T=001000 HLT=1 CON=3e3", i, bus.T, bus.HLT, bus.CON);
            else passed++;
            bus.OPCODE = 4'($urandom);
            tick();
        end
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        total++;
        if ({bus.T, bus.HLT, bus.CON} !== {6'b000001, 1'b0, 12'h5E3})
            $display("FAIL hlt_clear: got T=%b HLT=%b CON=%h, want T=000001 HLT=0 CON=5e3", bus.T, bus.HLT, bus.CON);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.OPCODE = 4'h1;
        repeat (4) tick();
        total++;
        if ({bus.T, bus.CON} !== {6'b010000, 12'h2E1})
            $display("FAIL mid_t5: got T=%b CON=%h, want T=010000 CON=2e1", bus.T, bus.CON);
        else passed++;
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        total++;
        if ({bus.T, bus.HLT, bus.CON[5], bus.CON} !== {6'b000001, 1'b0, 1'b1, 12'h5E3})
            $display("FAIL mid_clear: got T=%b HLT=%b CON=%h, want T=000001 HLT=0 CON=5e3", bus.T, bus.HLT, bus.CON);
        else passed++;
    endtask

    task automatic test_undef_selfcorrect();
        do_reset();
        bus.OPCODE = 4'h5;
        repeat (3) tick();
        for (int i = 0; i < NOP_LEN - 3; i++) begin
            total++;
            if ({bus.T, bus.CON} !== {6'(8 << i), 12'h3E3})
                $display("FAIL undef_t%0d: got T=%b CON=%h, want T=%b CON=3e3", i + 4, bus.T, bus.CON, 6'(8 << i));
            else passed++;
            tick();
        end
        total++;
        if (bus.T !== 6'b000001)
            $display("FAIL undef_wrap: got T=%b, want T=000001", bus.T);
        else passed++;
        force dut.u_ring.t_q = 6'b000110;
        #1;
        release dut.u_ring.t_q;
        #1;
        tick();
        total++;
        if ({bus.T, bus.CON} !== {6'b000001, 12'h5E3})
            $display("FAIL self_correct: got T=%b CON=%h, want T=000001 CON=5e3", bus.T, bus.CON);
        else passed++;
    endtask

    task automatic test_random();
        logic [3:0]  ins_op;
        logic [11:0] ec;
        do_reset();
        m_step = 1;
        m_hlt  = 1'b0;
        ins_op = 4'h0;
        for (int c = 0; c < 600; c++) begin
            CLR = ($urandom_range(0, 39) == 0);
            if (m_step <= 3) begin
                ins_op = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
                bus.OPCODE = (m_step == 3) ? ins_op : 4'($urandom);
            end else if (m_hlt) begin
                bus.OPCODE = 4'($urandom);
            end else begin
                bus.OPCODE = ins_op;
            end
            #1;
            ec = exp_con(m_step, bus.OPCODE, m_hlt);
            total++;
            if ({bus.T, bus.HLT, bus.CON} !== {6'(1 << (m_step - 1)), m_hlt, ec})
                $display("FAIL random_c%0d: got T=%b HLT=%b CON=%h, want T=%b HLT=%b CON=%h",
                         c, bus.T, bus.HLT, bus.CON, 6'(1 << (m_step - 1)), m_hlt, ec);
            else passed++;
            tick();
            if (CLR) begin
                m_step = 1;
                m_hlt  = 1'b0;
            end else if (!m_hlt) begin
                if (m_step == 4 && bus.OPCODE == 4'hF) m_hlt = 1'b1;
                else if (m_step >= instr_len(bus.OPCODE)) m_step = 1;
                else m_step++;
            end
        end
        CLR = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        CLR    = 1'b1;
        bus.OPCODE = 4'h0;
        test_reset();
        test_lda();
        test_add_sub();
        test_out_hlt();
        test_reset_mid();
        test_undef_selfcorrect();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sap1_controller_sequencer.md
Name: sap1_controller_sequencer

Overview:
- Control unit of the SAP-1 computer: 6-state one-hot ring counter (T1..T6) plus control matrix.
- Takes the 4-bit opcode from the instruction register (IR) upper nibble.
- Drives the 12-bit control word CON to the PC, MAR, RAM, IR, accumulator, adder/subtracter, B and output registers, plus the HLT flag.
- Sits directly downstream of the flip-flop primitives; consumes registered state and produces per-T-state register enables.

Parameters:
- OPCODE_W, 4, opcode width. Only 4 is supported; elaboration-time check fails on any other value.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- CLR  input  1  synchronous active-high reset.
- OPCODE  input  OPCODE_W  IR[7:4]; valid from T4 through T6.
- T  output  6  one-hot ring state; T[0]=T1 .. T[5]=T6.
- CON  output  12  control word, MSB..LSB: Cp Ep Lm_n CE_n Li_n Ei_n La_n Ea Su Eu Lb_n Lo_n (_n bits active-low).
- HLT  output  1  halt flag, registered.

Behaviour:
- Reset: on a posedge with CLR=1, T=6'b000001, HLT=0. CON then equals the T1 word 12'h5E3. CLR has priority over every other event, including halted and mid-instruction states.
- Ring: each posedge with CLR=0 and HLT=0 advances T1→T2→…→T6→T1. Fixed 6-cycle machine cycle.
- Self-correction: a non-one-hot T is reloaded to T1 on the next posedge.
- CON is combinational from T and OPCODE (no extra latency). Downstream registers sample it on the posedge that ends the state.
- Idle/NOP word: 12'h3E3.
- T1 (address): 12'h5E3 (Ep, Lm_n=0).
- T2 (increment): 12'hBE3 (Cp).
- T3 (memory): 12'h263 (CE_n=0, Li_n=0).
- T4:
  - LDA (0000), ADD (0001), SUB (0010): 12'h1A3 (Lm_n, Ei_n low).
  - OUT (1110): 12'h3F2 (Ea, Lo_n low).
  - HLT (1111): 12'h3E3.
  - Other opcodes: 12'h3E3.
- T5:
  - LDA: 12'h2C3 (CE_n, La_n low).
  - ADD/SUB: 12'h2E1 (CE_n, Lb_n low).
  - Other opcodes: 12'h3E3.
- T6:
  - ADD: 12'h3C7 (La_n low, Eu).
  - SUB: 12'h3CF (La_n low, Su, Eu).
  - Other opcodes: 12'h3E3.
- Halt: on the posedge ending T4 with OPCODE=1111, HLT←1 and T is held at T4.
  - While HLT=1: CON is forced to 12'h3E3, T frozen, OPCODE ignored.
  - Only CLR clears HLT.
- Undefined opcodes (0011..1101) execute as 6-cycle NOP.
- OPCODE changes are not recognised at T1–T3 (CON there is opcode-independent).

Optional Feature:
- Macro: SAP1_SHORT_CYCLE_EN.
- Defined (variable machine cycle):
  - After T4, return to T1 for OUT, NOP and undefined opcodes.
  - After T5, return to T1 for LDA.
  - ADD/SUB still use T6.
  - HLT behaviour unchanged.
- Undefined: fixed 6-state cycle for every opcode.

Decomposition:
- Package sap1_pkg holds:
  - Opcode enum (OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT).
  - CON bit-index constants.
  - Named CON constants (CON_IDLE, CON_T1, CON_T2, CON_T3, CON_MAR_IR, CON_OUT, CON_LDA_RAM, CON_B_RAM, CON_ADD, CON_SUB).
  - T-state one-hot localparams.
- Sub-module ring_counter_6: one-hot register with CLR, hold (from HLT), load-T1 (short-cycle/self-correct) inputs.
- Control matrix and halt latch stay in the top.

Test Plan:
- Reset: CLR=1 for 2 cycles → T=000001, HLT=0, CON=5E3. Release CLR → successive cycles CON=5E3, BE3, 263.
- LDA: OPCODE=0000 → T4..T6 CON=1A3, 2C3, 3E3. Then T=000001 again (with SAP1_SHORT_CYCLE_EN: T1 directly after T5).
- ADD then SUB: T6 CON=3C7 for 0001 and 3CF for 0010. T5 CON=2E1 for both.
- OUT then HLT: T4 CON=3F2 for 1110. For 1111, HLT=1 after the T4 edge; T stays 001000 and CON stays 3E3 for 20 cycles; CLR → T1, HLT=0.
- Reset mid-operation: CLR asserted during T5 of ADD → next posedge T=000001, CON=5E3, no La_n pulse occurs.
- Undefined opcode 0101 → T4..T6 CON=3E3; force T=000110 via bench → T1 on the next edge.
